// File: rtl/serial_in.sv
// -----------------------------------------------------------------------------
// serial_in -- serial-to-parallel byte receiver
//
// Receives frames from a one-bit-per-clock serial line that idles high.
// Frame: start bit (0), then 8 data bits MSB first, then the line returns high
// (stop bit). There is no oversampling; every dataClk rising edge samples
// exactly one bit. A received byte is held in a one-deep holding register
// until the consumer accepts it.
//
// Optional build macro:
//   FRAME_CHECK_EN  - adds STOP and WAIT_HIGH states. The stop bit is sampled
//                     on its own edge. A 0 there drops the byte, pulses
//                     frameErr, and the receiver waits for the line to go
//                     high again. Without the macro the byte completes on
//                     the last data bit and frameErr is tied low.
//
// Ports:
//   dataClk          in   clock, all state changes on the rising edge
//   rst_n            in   asynchronous active-low reset; release is synchronized
//   serialDataIn     in   serial line, idle high
//   dataReady        in   consumer accepts the held byte (ignored when empty)
//   parallelDataOut  out  [7:0] last loaded byte
//   dataValid        out  parallelDataOut holds an unconsumed byte
//   overrun          out  sticky: a completed byte was dropped (cleared by reset)
//   frameErr         out  one-cycle pulse on a bad stop bit
//
// Handshake: a byte is transferred on a rising edge where dataValid=1 and
// dataReady=1. dataValid may not drop without such a transfer. A new byte
// may be loaded on the same edge that the held byte is transferred.
// -----------------------------------------------------------------------------
module serial_in (
    input  logic       dataClk,
    input  logic       rst_n,
    input  logic       serialDataIn,
    input  logic       dataReady,
    output logic [7:0] parallelDataOut,
    output logic       dataValid,
    output logic       overrun,
    output logic       frameErr
);

`ifdef FRAME_CHECK_EN
    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        DATA      = 2'd1,
        STOP      = 2'd2,
        WAIT_HIGH = 2'd3
    } state_t;
`else
    typedef enum logic {
        IDLE = 1'b0,
        DATA = 1'b1
    } state_t;
`endif

    // FSM state; kept as a named signal so checkers can bind to it.
    state_t     state;
    state_t     stateNext;

    logic [2:0] bitCnt;
    logic [2:0] bitCntNext;
    logic [7:0] shiftReg;
    logic [7:0] shiftNext;

    // Completion strobe and the byte to load on that edge.
    logic       byteDone;
    logic [7:0] byteNext;

`ifdef FRAME_CHECK_EN
    logic       frameBad;
`endif

    // -------------------------------------------------------------------------
    // Reset release. Assertion is asynchronous through every flop. runEn
    // follows release by one edge, so the first edge that updates state is
    // the second rising edge after rst_n goes high.
    // -------------------------------------------------------------------------
    logic runEn;

    always_ff @(posedge dataClk or negedge rst_n) begin
        if (!rst_n) begin
            runEn <= 1'b0;
        end else begin
            runEn <= 1'b1;
        end
    end

    // -------------------------------------------------------------------------
    // Receive FSM: state register
    // -------------------------------------------------------------------------
    always_ff @(posedge dataClk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            bitCnt   <= 3'd0;
            shiftReg <= 8'h00;
        end else if (runEn) begin
            state    <= stateNext;
            bitCnt   <= bitCntNext;
            shiftReg <= shiftNext;
        end
    end

    // -------------------------------------------------------------------------
    // Receive FSM: next state and completion decode
    // -------------------------------------------------------------------------
    always_comb begin
        stateNext  = state;
        bitCntNext = bitCnt;
        shiftNext  = shiftReg;
        byteDone   = 1'b0;
        byteNext   = shiftReg;
`ifdef FRAME_CHECK_EN
        frameBad   = 1'b0;
`endif

        case (state)
            IDLE: begin
                // A sampled 0 is the start bit. A 1 keeps the line idle.
                if (!serialDataIn) begin
                    stateNext  = DATA;
                    bitCntNext = 3'd0;
                end
            end

            DATA: begin
                shiftNext  = {shiftReg[6:0], serialDataIn};
                // 3-bit counter wraps 7 -> 0 on the last data bit.
                bitCntNext = bitCnt + 3'd1;
                if (bitCnt == 3'd7) begin
`ifdef FRAME_CHECK_EN
                    stateNext = STOP;
`else
                    // The byte is complete on this edge. Return to IDLE
                    // so a start bit on the very next edge is accepted.
                    stateNext = IDLE;
                    byteDone  = 1'b1;
                    byteNext  = {shiftReg[6:0], serialDataIn};
`endif
                end
            end

`ifdef FRAME_CHECK_EN
            STOP: begin
                if (serialDataIn) begin
                    stateNext = IDLE;
                    byteDone  = 1'b1;
                end else begin
                    // Bad stop bit. Drop the byte and do not accept a new
                    // start until the line has been seen high again.
                    stateNext = WAIT_HIGH;
                    frameBad  = 1'b1;
                end
            end

            WAIT_HIGH: begin
                if (serialDataIn) begin
                    stateNext = IDLE;
                end
            end
`endif

            default: begin
                stateNext = IDLE;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // Holding register and status flags.
    // A completing byte loads when the holder is empty or is being emptied
    // on this same edge. Otherwise the new byte is lost and overrun sets.
    // parallelDataOut changes only on a load.
    // -------------------------------------------------------------------------
    always_ff @(posedge dataClk or negedge rst_n) begin
        if (!rst_n) begin
            parallelDataOut <= 8'h00;
            dataValid       <= 1'b0;
            overrun         <= 1'b0;
        end else if (runEn) begin
            if (byteDone) begin
                if (!dataValid || dataReady) begin
                    parallelDataOut <= byteNext;
                    dataValid       <= 1'b1;
                end else begin
                    overrun <= 1'b1;
                end
            end else if (dataValid && dataReady) begin
                dataValid <= 1'b0;
            end
        end
    end

`ifdef FRAME_CHECK_EN
    // One-cycle pulse, registered on the edge that sampled the bad stop bit.
    always_ff @(posedge dataClk or negedge rst_n) begin
        if (!rst_n) begin
            frameErr <= 1'b0;
        end else if (runEn) begin
            frameErr <= frameBad;
        end
    end
`else
    assign frameErr = 1'b0;
`endif

endmodule
